vend_dispenser: RTL
===================

Name: vend_dispenser

Overview:
- Downstream stage of vending_machine.
- Consumes its one-cycle item/change codes and drives the physical actuators: an item motor (20- or 50-unit product) and a coin ejector that emits change as a train of 10-unit coin pulses.
- Provides busy/done status, plus a one-entry pending buffer so back-to-back vends are not lost.

Parameters:
- MOTOR_CYCLES, 4, cycles the motor output is held high per item (>=1).
- COIN_ON_CYCLES, 2, high time of each coin pulse (>=1).
- COIN_OFF_CYCLES, 2, low gap between consecutive coin pulses (>=1).
- CNT_W, 8, phase timer width; must hold max(MOTOR_CYCLES, COIN_ON_CYCLES, COIN_OFF_CYCLES).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high.
- item  input  2  vend code from vending_machine: 00 none, 01 twenty-item, 10 fifty-item, 11 illegal (treated as 00).
- change  input  2  change code: 00 none, 01 = 10, 10 = 30, 11 = 40 (coin counts 0/1/3/4).
- busy  output  1  high while a vend is executing.
- motor_twenty  output  1  twenty-item motor drive.
- motor_fifty  output  1  fifty-item motor drive.
- coin_out  output  1  coin ejector pulse, one pulse per 10 units.
- done  output  1  one-cycle pulse at the end of each vend.
- overrun  output  1  sticky; an event was dropped.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high. All outputs are registered.
- Reset values: every output is 0; state is IDLE; the pending buffer is empty.
- Event definition: a cycle where item != 00 (and not 11) or change != 00. The inputs are single-cycle and are sampled every edge.
- States: IDLE, MOTOR, COIN_ON, COIN_OFF, DONE.
- IDLE, event sampled at edge ending cycle N:
  - Capture item and coin count.
  - If an item is present, go to MOTOR; otherwise go to COIN_ON if coins > 0.
- MOTOR:
  - The selected motor output is high for cycles N+1 .. N+MOTOR_CYCLES.
  - Then go to COIN_ON if coins > 0, else DONE.
- COIN_ON: coin_out high for COIN_ON_CYCLES; decrement the remaining count. Then go to COIN_OFF if coins remain, else DONE.
- COIN_OFF: coin_out low for COIN_OFF_CYCLES, then COIN_ON. There is no gap after the last coin.
- DONE: done=1 for exactly one cycle.
  - If the pending buffer is valid, start the pending vend next cycle (MOTOR/COIN_ON as above), and accept a same-cycle input into the freed pending slot.
  - Else, if an input event is present this cycle, start it directly.
  - Else go to IDLE.
- busy: high in every non-IDLE state, from cycle N+1 through the DONE cycle inclusive.
- Events while busy (non-IDLE, non-DONE):
  - Stored in the pending buffer if it is empty.
  - If pending is full, the event is dropped and overrun is set to 1 until reset.
- Exclusivity: motor_twenty, motor_fifty and coin_out are never high simultaneously.
- Reset mid-operation: on the next edge all outputs go to 0, pending is cleared, overrun is cleared, and state returns to IDLE. No partial pulse resumes.
- Edge cases:
  - Change-only event with change=00 and illegal item=11 is not an event.
  - Item with change=00 goes MOTOR then DONE.

Decomposition:
- Shared package vending_pkg holds:
  - item, change and money encodings (shared with vending_machine);
  - a function change_to_coins (2-bit code to 3-bit count);
  - the dispenser state enum.
- No sub-module. A single down-counter phase timer is reloaded on each state entry.

Test Plan:
- item=01, change=11 at cycle 0 -> motor_twenty high cycles 1-4; coin_out high 5-6, 9-10, 13-14, 17-18; done at 19; busy 1-19; then IDLE.
- item=10, change=01 at cycle 0 -> motor_fifty high 1-4; coin_out high 5-6; done at 7; motor_twenty never high.
- item=01, change=00 at cycle 0 -> motor_twenty high 1-4; done at 5; coin_out never high.
- Events at cycles 0 (01/10), 2 (01/00) and 3 (10/00):
  - first vend: motor_twenty 1-4, coin pulses 5-6, 9-10, 13-14, done at 15;
  - second event held in pending, third event dropped, overrun=1 from cycle 4;
  - second vend starts at 16: motor_twenty 16-19, done at 20;
  - no fifty vend occurs.
- Event arrives in the DONE cycle with pending empty -> new vend starts the next cycle with no IDLE gap, and done pulses once per vend.
- item=01, change=11 at 0; reset asserted in cycle 6 -> all outputs 0 from cycle 7; a later event executes normally from a fresh start; overrun is 0.

Source files
------------

// File: rtl/vending_pkg.sv
// rtl/vending_pkg.sv - encodings, coin decode and dispenser state shared by the vending blocks
// Contents: item/change codes, money values, change_to_coins(), disp_state_t.
package vending_pkg;

  typedef enum logic [1:0] {
    ITEM_NONE    = 2'b00,
    ITEM_TWENTY  = 2'b01,
    ITEM_FIFTY   = 2'b10,
    ITEM_ILLEGAL = 2'b11
  } item_t;

  typedef enum logic [1:0] {
    CHG_NONE = 2'b00,
    CHG_10   = 2'b01,
    CHG_30   = 2'b10,
    CHG_40   = 2'b11
  } change_t;

  localparam int unsigned COIN_VALUE   = 10;
  localparam int unsigned PRICE_TWENTY = 20;
  localparam int unsigned PRICE_FIFTY  = 50;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_MOTOR    = 3'd1,
    ST_COIN_ON  = 3'd2,
    ST_COIN_OFF = 3'd3,
    ST_DONE     = 3'd4
  } disp_state_t;

  // Change code to number of 10-unit coins to eject.
  function automatic logic [2:0] change_to_coins(input change_t c);
    case (c)
      CHG_10:  change_to_coins = 3'd1;
      CHG_30:  change_to_coins = 3'd3;
      CHG_40:  change_to_coins = 3'd4;
      default: change_to_coins = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/vend_dispenser.sv
// rtl/vend_dispenser.sv - drives item motors and coin ejector from vend/change codes
// Ports: clk, reset (sync, active-high); item[1:0], change[1:0] single-cycle codes;
//        busy, motor_twenty, motor_fifty, coin_out, done (1-cycle), overrun (sticky).
module vend_dispenser
  import vending_pkg::*;
#(
  parameter int unsigned MOTOR_CYCLES    = 4,
  parameter int unsigned COIN_ON_CYCLES  = 2,
  parameter int unsigned COIN_OFF_CYCLES = 2,
  parameter int unsigned CNT_W           = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] item,
  input  logic [1:0] change,
  output logic       busy,
  output logic       motor_twenty,
  output logic       motor_fifty,
  output logic       coin_out,
  output logic       done,
  output logic       overrun
);

  localparam logic [CNT_W-1:0] MOTOR_LOAD = CNT_W'(MOTOR_CYCLES - 1);
  localparam logic [CNT_W-1:0] ON_LOAD    = CNT_W'(COIN_ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] OFF_LOAD   = CNT_W'(COIN_OFF_CYCLES - 1);

  disp_state_t      state_q;
  logic [CNT_W-1:0] timer_q;
  logic [2:0]       coins_q;
  logic             pend_valid_q;
  item_t            pend_item_q;
  logic [2:0]       pend_coins_q;
  logic             busy_q, motor_twenty_q, motor_fifty_q, coin_q, done_q, overrun_q;

  item_t      ev_item;
  logic [2:0] ev_coins;
  logic       ev_valid;
  logic       src_pend;
  item_t      st_item;
  logic [2:0] st_coins;
  logic       st_valid;

  // Decode the incoming codes; an illegal item is treated as no item.
  // In DONE a valid pending entry takes priority over the live input.
  always_comb begin
    ev_item  = (item_t'(item) == ITEM_ILLEGAL) ? ITEM_NONE : item_t'(item);
    ev_coins = change_to_coins(change_t'(change));
    ev_valid = (ev_item != ITEM_NONE) || (ev_coins != 3'd0);
    src_pend = (state_q == ST_DONE) && pend_valid_q;
    st_item  = src_pend ? pend_item_q  : ev_item;
    st_coins = src_pend ? pend_coins_q : ev_coins;
    st_valid = src_pend || ev_valid;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      timer_q        <= '0;
      coins_q        <= '0;
      pend_valid_q   <= 1'b0;
      pend_item_q    <= ITEM_NONE;
      pend_coins_q   <= '0;
      busy_q         <= 1'b0;
      motor_twenty_q <= 1'b0;
      motor_fifty_q  <= 1'b0;
      coin_q         <= 1'b0;
      done_q         <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          done_q <= 1'b0;
          // Pending slot is freed this cycle, so a same-cycle input refills it.
          if (src_pend) begin
            pend_valid_q <= ev_valid;
            pend_item_q  <= ev_item;
            pend_coins_q <= ev_coins;
          end
          if (st_valid) begin
            busy_q  <= 1'b1;
            coins_q <= st_coins;
            if (st_item != ITEM_NONE) begin
              state_q        <= ST_MOTOR;
              motor_twenty_q <= (st_item == ITEM_TWENTY);
              motor_fifty_q  <= (st_item == ITEM_FIFTY);
              timer_q        <= MOTOR_LOAD;
            end else begin
              state_q <= ST_COIN_ON;
              coin_q  <= 1'b1;
              timer_q <= ON_LOAD;
            end
          end else begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        ST_MOTOR: begin
          if (timer_q == '0) begin
            motor_twenty_q <= 1'b0;
            motor_fifty_q  <= 1'b0;
            if (coins_q != 3'd0) begin
              state_q <= ST_COIN_ON;
              coin_q  <= 1'b1;
              timer_q <= ON_LOAD;
            end else begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end
          end else begin
            timer_q <= timer_q - CNT_W'(1);
          end
        end
        ST_COIN_ON: begin
          if (timer_q == '0) begin
            coin_q  <= 1'b0;
            coins_q <= coins_q - 3'd1;
            // No trailing gap after the last coin.
            if (coins_q > 3'd1) begin
              state_q <= ST_COIN_OFF;
              timer_q <= OFF_LOAD;
            end else begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end
          end else begin
            timer_q <= timer_q - CNT_W'(1);
          end
        end
        ST_COIN_OFF: begin
          if (timer_q == '0) begin
            state_q <= ST_COIN_ON;
            coin_q  <= 1'b1;
            timer_q <= ON_LOAD;
          end else begin
            timer_q <= timer_q - CNT_W'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase

      // Events arriving mid-vend go to the single pending slot or are dropped.
      if ((state_q == ST_MOTOR || state_q == ST_COIN_ON || state_q == ST_COIN_OFF) && ev_valid) begin
        if (!pend_valid_q) begin
          pend_valid_q <= 1'b1;
          pend_item_q  <= ev_item;
          pend_coins_q <= ev_coins;
        end else begin
          overrun_q <= 1'b1;
        end
      end
    end
  end

  assign busy         = busy_q;
  assign motor_twenty = motor_twenty_q;
  assign motor_fifty  = motor_fifty_q;
  assign coin_out     = coin_q;
  assign done         = done_q;
  assign overrun      = overrun_q;

endmodule
